// File: rtl/seg7_scan_rx.sv
// seg7_scan_rx: receiver for a multiplexed 4-digit 7-segment display bus.
// The block synchronizes the digit enables and segment lines, waits for each
// pattern to hold steady, and captures the decoded digit at the enabled
// position. Once all four positions have been seen, it delivers them as one
// frame. A partial frame with no progress for TIMEOUT_CYCLES is dropped and
// the stale flag is raised.
module seg7_scan_rx #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048575
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [3:0]  an_in,
  input  logic [6:0]  seg_in,
  output logic [15:0] digits,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        seg_err,
  output logic        an_err,
  output logic        stale
);

  localparam int SW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_PRE  = SW'(STABLE_CYCLES - 2);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  // Active-low a..g pattern to BCD digit; unknown patterns map to 4'hF.
  function automatic logic [3:0] seg_decode(input logic [6:0] seg);
    logic [3:0] d;
    case (seg)
      7'b0000001: d = 4'd0;
      7'b1001111: d = 4'd1;
      7'b0010010: d = 4'd2;
      7'b0000110: d = 4'd3;
      7'b1001100: d = 4'd4;
      7'b0100100: d = 4'd5;
      7'b0100000: d = 4'd6;
      7'b0001111: d = 4'd7;
      7'b0000000: d = 4'd8;
      7'b0000100: d = 4'd9;
      default:    d = 4'hF;
    endcase
    return d;
  endfunction

  logic [3:0]    r_an_s1, r_an_s2, r_an_prev;
  logic [6:0]    r_seg_s1, r_seg_s2, r_seg_prev;
  logic [SW-1:0] r_cnt;
  logic [TW-1:0] r_tcnt;
  logic [3:0]    r_seen;
  logic [3:0]    r_dig [4];
  state_t        r_state;

  logic          w_same;
  logic          w_event;
  logic          w_an_one;
  logic          w_an_multi;
  logic          w_capture;
  logic [3:0]    w_cap_vec;
  logic [3:0]    w_dec;
  logic          w_complete;
  logic          w_timeout;
  logic          w_any_f;
  state_t        w_state_nxt;

  // Two-flop synchronizers on the display bus, plus the previous synced sample.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_an_s1    <= 4'hF;
      r_an_s2    <= 4'hF;
      r_an_prev  <= 4'hF;
      r_seg_s1   <= 7'h7F;
      r_seg_s2   <= 7'h7F;
      r_seg_prev <= 7'h7F;
    end else begin
      r_an_s1    <= an_in;
      r_an_s2    <= r_an_s1;
      r_an_prev  <= r_an_s2;
      r_seg_s1   <= seg_in;
      r_seg_s2   <= r_seg_s1;
      r_seg_prev <= r_seg_s2;
    end
  end

  assign w_same     = (r_an_s2 == r_an_prev) && (r_seg_s2 == r_seg_prev);
  // One event per stable dwell: only on the step into the saturated count.
  assign w_event    = w_same && (r_cnt == STABLE_PRE);
  assign w_an_one   = $onehot(~r_an_s2);
  assign w_an_multi = (r_an_s2 != 4'hF) && !w_an_one;
  assign w_capture  = w_event && w_an_one;
  assign w_cap_vec  = w_capture ? ~r_an_s2 : 4'b0000;
  assign w_dec      = seg_decode(r_seg_s2);
  assign w_any_f    = (r_dig[0] == 4'hF) || (r_dig[1] == 4'hF) ||
                      (r_dig[2] == 4'hF) || (r_dig[3] == 4'hF);

  // Stability counter: restart on any change, saturate once stable.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt <= '0;
    end else if (!w_same) begin
      r_cnt <= '0;
    end else if (r_cnt != STABLE_LAST) begin
      r_cnt <= r_cnt + SW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Per-position digit storage, overwritten on every capture at that position.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < 4; i++) r_dig[i] <= 4'h0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_cap_vec[i]) r_dig[i] <= w_dec;
      end
    end
  end

  // Positions captured in the frame being collected.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_seen <= 4'b0000;
    end else if (w_complete || w_timeout) begin
      r_seen <= 4'b0000;
    end else begin
      r_seen <= r_seen | w_cap_vec;
    end
  end

  // Inactivity counter: runs only while collecting, cleared by each capture.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_tcnt <= '0;
    end else if (w_capture || (r_state == ST_IDLE)) begin
      r_tcnt <= '0;
    end else if (r_tcnt != TIMEOUT_LAST) begin
      r_tcnt <= r_tcnt + TW'(1);
    end else begin
      r_tcnt <= r_tcnt;
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Frame FSM next state: completion, then capture (beats timeout), then timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_complete  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_capture) w_state_nxt = ST_COLLECT;
        else           w_state_nxt = ST_IDLE;
      end
      ST_COLLECT: begin
        if (r_seen == 4'b1111) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_capture) begin
          w_state_nxt = ST_COLLECT;
        end else if (r_tcnt == TIMEOUT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_COLLECT;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs: frame delivery, error pulses and the stale flag.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      digits      <= 16'h0000;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      seg_err     <= 1'b0;
      an_err      <= 1'b0;
      stale       <= 1'b1;
    end else begin
      frame_valid <= w_complete;
      seg_err     <= w_capture && (w_dec == 4'hF);
      an_err      <= w_event && w_an_multi;
      if (w_complete) begin
        digits    <= {r_dig[3], r_dig[2], r_dig[1], r_dig[0]};
        frame_err <= w_any_f;
        stale     <= 1'b0;
      end else if (w_timeout) begin
        stale     <= 1'b1;
      end else begin
        stale     <= stale;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_rx.sv
// Directed testbench for seg7_scan_rx with hand-computed expected values.
module tb_seg7_scan_rx;

  localparam logic [6:0] S0   = 7'b0000001;
  localparam logic [6:0] S1   = 7'b1001111;
  localparam logic [6:0] S3   = 7'b0000110;
  localparam logic [6:0] S5   = 7'b0100100;
  localparam logic [6:0] S8   = 7'b0000000;
  localparam logic [6:0] S9   = 7'b0000100;
  localparam logic [6:0] SBAD = 7'b1111111;

  logic        clk;
  logic        clr;
  logic [3:0]  an_in;
  logic [6:0]  seg_in;
  logic [15:0] digits;
  logic        frame_valid;
  logic        frame_err;
  logic        seg_err;
  logic        an_err;
  logic        stale;

  int n_checks = 0;
  int n_errors = 0;
  int n_fv     = 0;
  int n_se     = 0;
  int n_ae     = 0;

  seg7_scan_rx #(
    .STABLE_CYCLES  (16),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .an_in       (an_in),
    .seg_in      (seg_in),
    .digits      (digits),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .seg_err     (seg_err),
    .an_err      (an_err),
    .stale       (stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count high cycles of each pulse output, sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_valid) n_fv <= n_fv + 1;
    if (seg_err)     n_se <= n_se + 1;
    if (an_err)      n_ae <= n_ae + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
    an_in  = an;
    seg_in = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scan order d0, d1, d2, d3; each held 20 cycles.
  task automatic scan(input logic [6:0] s3, input logic [6:0] s2,
                      input logic [6:0] s1, input logic [6:0] s0);
    hold(4'b1110, s0, 20);
    hold(4'b1101, s1, 20);
    hold(4'b1011, s2, 20);
    hold(4'b0111, s3, 20);
  endtask

  initial begin
    // 1: reset with random inputs
    clr    = 1'b1;
    an_in  = 4'($urandom);
    seg_in = 7'($urandom);
    repeat (4) @(posedge clk);
    #1;
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_fv", 32'(frame_valid), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    chk("rst_seg_err", 32'(seg_err), 32'h0);
    chk("rst_an_err", 32'(an_err), 32'h0);
    chk("rst_stale", 32'(stale), 32'h1);
    clr = 1'b0;
    hold(4'b1111, 7'($urandom), 40);
    chk("blank_fv_cnt", 32'(n_fv), 32'd0);
    chk("blank_se_cnt", 32'(n_se), 32'd0);
    chk("blank_ae_cnt", 32'(n_ae), 32'd0);
    chk("blank_stale", 32'(stale), 32'h1);

    // 2: clean scan 3,0,5,9 twice
    scan(S3, S0, S5, S9);
    chk("scan1_fv_cnt", 32'(n_fv), 32'd1);
    chk("scan1_digits", 32'(digits), 32'h3059);
    chk("scan1_ferr", 32'(frame_err), 32'h0);
    chk("scan1_stale", 32'(stale), 32'h0);
    scan(S3, S0, S5, S9);
    chk("scan2_fv_cnt", 32'(n_fv), 32'd2);
    chk("scan2_digits", 32'(digits), 32'h3059);

    // 3: short glitch of 8 before a stable 1 on position 0
    hold(4'b1110, S8, 5);
    hold(4'b1110, S1, 30);
    hold(4'b1101, S5, 20);
    hold(4'b1011, S0, 20);
    hold(4'b0111, S3, 20);
    chk("glitch_fv_cnt", 32'(n_fv), 32'd3);
    chk("glitch_digits", 32'(digits), 32'h3051);
    chk("glitch_se_cnt", 32'(n_se), 32'd0);

    // 4: undecodable pattern on position 1
    scan(S3, S0, SBAD, S9);
    chk("bad_se_cnt", 32'(n_se), 32'd1);
    chk("bad_fv_cnt", 32'(n_fv), 32'd4);
    chk("bad_digits", 32'(digits), 32'h30F9);
    chk("bad_ferr", 32'(frame_err), 32'h1);

    // 5: two enables low -> single an_err, then a normal frame
    hold(4'b1100, S8, 40);
    chk("an2_ae_cnt", 32'(n_ae), 32'd1);
    chk("an2_fv_cnt", 32'(n_fv), 32'd4);
    scan(S3, S0, S5, S9);
    chk("an2_scan_fv_cnt", 32'(n_fv), 32'd5);
    chk("an2_scan_digits", 32'(digits), 32'h3059);
    chk("an2_scan_ferr", 32'(frame_err), 32'h0);

    // 6: partial frame then timeout
    hold(4'b1110, S9, 20);
    hold(4'b1101, S5, 20);
    chk("part_stale", 32'(stale), 32'h0);
    hold(4'b1111, S8, 150);
    chk("to_stale", 32'(stale), 32'h1);
    chk("to_fv_cnt", 32'(n_fv), 32'd5);
    chk("to_digits", 32'(digits), 32'h3059);
    hold(4'b1011, S0, 20);
    hold(4'b0111, S3, 20);
    chk("to_discard_fv_cnt", 32'(n_fv), 32'd5);
    hold(4'b1111, S8, 150);
    chk("to2_stale", 32'(stale), 32'h1);

    // 6b: clr mid-frame discards the partial frame
    hold(4'b1110, S1, 20);
    hold(4'b1101, S1, 20);
    clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("clr_digits", 32'(digits), 32'h0);
    chk("clr_stale", 32'(stale), 32'h1);
    chk("clr_ferr", 32'(frame_err), 32'h0);
    chk("clr_fv", 32'(frame_valid), 32'h0);
    clr = 1'b0;
    hold(4'b1011, S0, 20);
    hold(4'b0111, S3, 20);
    chk("clr_discard_fv_cnt", 32'(n_fv), 32'd5);
    scan(S3, S0, S5, S9);
    chk("post_clr_fv_cnt", 32'(n_fv), 32'd6);
    chk("post_clr_digits", 32'(digits), 32'h3059);
    chk("post_clr_stale", 32'(stale), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
